// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
//   tx_state_e    : serialiser FSM states
//   ST_*          : bit positions inside the status word
//   ADDR_UART*    : decoder addresses (data/status at UART, ack read at UART+1)
//   status_word() : packs the status fields into the 16-bit read value
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int ST_READY   = 0;
  localparam int ST_BUSY    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  localparam logic [15:0] ADDR_UART     = 16'h0F00;
  localparam logic [15:0] ADDR_UART_ACK = ADDR_UART + 16'd1;

  function automatic logic [15:0] status_word(input logic       ready,
                                              input logic       busy,
                                              input logic       ovf,
                                              input logic [2:0] cnt);
    logic [15:0] s;
    s                  = '0;
    s[ST_READY]        = ready;
    s[ST_BUSY]         = busy;
    s[ST_OVF]          = ovf;
    s[ST_CNT_LSB +: 3] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO feeding the UART serialiser.
//   clk, reset : system clock, synchronous active-high flush
//   push, din  : write request and byte; ignored while full
//   pop, dout  : read request; dout always shows the head entry
//   count      : occupancy 0..DEPTH
//   full/empty : derived from the registered count
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the flushed count marks every entry invalid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter.
//   clk, reset   : system clock, synchronous active-high reset
//   wr, datain   : one-cycle write strobe; datain[7:0] is queued
//   statusordata : 1 selects the status word onto dataout, 0 drives zero
//   ack          : one-cycle pulse clearing the sticky overflow flag
//   dataout      : combinational read value for the CPU
//   txd          : registered serial output, idles high
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more bytes wait
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic [15:0] datain,
  input  logic        statusordata,
  input  logic        ack,
  output logic [15:0] dataout,
  output logic        txd
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              txd_q, txd_d;
  logic              ovf_q, ovf_d;

  logic              fifo_pop;
  logic [7:0]        fifo_dout;
  logic [FIFO_AW:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              baud_done;
  logic              unused_datain_hi;

  assign unused_datain_hi = ^datain[15:8];

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr),
    .din   (datain[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_done = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          baud_d   = '0;
          state_d  = START;
          txd_d    = 1'b0;
        end
      end

      START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          txd_d     = shreg_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = shreg_q >> 1;
            // Next bit is presented on the same edge the shift happens.
            txd_d     = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            // Back-to-back frame: no idle gap between stop and start.
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            state_d  = START;
            txd_d    = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // A dropped write beats a coincident ack so software never misses a loss.
  always_comb begin
    ovf_d = ovf_q;
    if (wr && fifo_full) ovf_d = 1'b1;
    else if (ack)        ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign txd = txd_q;

  always_comb begin
    dataout = 16'h0000;
    if (statusordata) begin
      dataout = status_word(!fifo_full,
                            (state_q != IDLE) || !fifo_empty,
                            ovf_q,
                            3'(fifo_count));
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [15:0] datain;
  logic        statusordata;
  logic        ack;
  logic [15:0] dataout;
  logic        txd;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int rx_count = 0;
  int rx_starts[$];
  logic [7:0] exp_q[$];

  logic rx_busy;
  int   rx_tick;
  logic [7:0] rx_byte;

  uart_tx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .FIFO_AW      (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .datain       (datain),
    .statusordata (statusordata),
    .ack          (ack),
    .dataout      (dataout),
    .txd          (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    int b;
    b = 0;
    while (rx_count < target && b < budget) begin
      @(negedge clk);
      b++;
    end
    check(tag, 16'(rx_count), 16'(target));
  endtask

  // Serial receiver: samples mid-bit #1 after each rising edge and pops the scoreboard.
  initial begin
    logic [7:0] e;
    rx_busy = 1'b0;
    rx_tick = 0;
    rx_byte = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (txd === 1'b0) begin
          rx_busy = 1'b1;
          rx_tick = 0;
          rx_starts.push_back(cyc);
        end
      end else begin
        rx_tick++;
        if (rx_tick == CPB / 2) begin
          check("rx_start_bit", 16'(txd), 16'd0);
        end else if (rx_tick >= CPB + CPB / 2 && rx_tick < 9 * CPB &&
                     ((rx_tick - CPB / 2) % CPB) == 0) begin
          rx_byte[(rx_tick - CPB - CPB / 2) / CPB] = txd;
        end else if (rx_tick == 9 * CPB + CPB / 2) begin
          check("rx_stop_bit", 16'(txd), 16'd1);
          if (exp_q.size() == 0) begin
            check("rx_unexpected_frame", 16'(rx_byte), 16'hxxxx);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", 16'(rx_byte), 16'(e));
          end
          rx_count++;
          rx_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   base;
    int   n;
    logic [7:0] burst[6];
    logic [7:0] quad[5];

    reset = 1'b1;
    wr = 1'b0;
    datain = '0;
    statusordata = 1'b1;
    ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // 1. reset state and idle line
    check("reset_status", dataout, 16'h0001);
    check("reset_txd", 16'(txd), 16'd1);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (txd !== 1'b1) ok = 1'b0;
    end
    check("idle_hold_100", 16'(ok), 16'd1);

    // 2. single frame A5, latency and frame length
    base = rx_count;
    wr = 1'b1;
    datain = 16'h12A5;
    exp_q.push_back(8'hA5);
    tick(1);
    wr = 1'b0;
    check("lat_edge_n_txd", 16'(txd), 16'd1);
    check("lat_edge_n_status", dataout, 16'h0013);
    tick(1);
    check("lat_edge_n1_txd", 16'(txd), 16'd0);
    check("frame_busy_status", dataout, 16'h0003);
    tick(39);
    check("frame_last_cycle_busy", dataout, 16'h0003);
    tick(1);
    check("frame_done_status", dataout, 16'h0001);
    check("frame_a5_received", 16'(rx_count), 16'(base + 1));

    // 3. back-to-back frames
    tick(5);
    base = rx_count;
    wr = 1'b1;
    datain = 16'h0001;
    exp_q.push_back(8'h01);
    tick(1);
    datain = 16'h0080;
    exp_q.push_back(8'h80);
    tick(1);
    wr = 1'b0;
    wait_rx("b2b_frames", base + 2, 200);
    n = rx_starts.size();
    if (n >= 2) check("b2b_start_gap", 16'(rx_starts[n-1] - rx_starts[n-2]), 16'd40);
    else check("b2b_start_count", 16'(n), 16'd2);
    tick(10);
    check("b2b_idle_status", dataout, 16'h0001);

    // 4. overflow: six writes, fifth fills, sixth dropped
    base = rx_count;
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h55; burst[5] = 8'h66;
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1;
      datain = {8'h00, burst[i]};
      if (i < 5) exp_q.push_back(burst[i]);
      tick(1);
    end
    wr = 1'b0;
    check("ovf_status", dataout, 16'h0046);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_clears_ovf", dataout, 16'h0042);
    wr = 1'b1;
    datain = 16'h00EE;
    ack = 1'b1;
    tick(1);
    wr = 1'b0;
    ack = 1'b0;
    check("ovf_set_beats_ack", dataout, 16'h0046);
    wait_rx("ovf_frames", base + 5, 5 * 40 + 60);
    check("ovf_queue_drained", 16'(exp_q.size()), 16'd0);
    tick(5);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ovf_final_status", dataout, 16'h0001);

    // 5. reset during DATA bit 3 with two bytes queued
    tick(3);
    exp_q.push_back(8'h37);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    wr = 1'b1; datain = 16'h0037; tick(1);
    datain = 16'h00C3; tick(1);
    datain = 16'h005A; tick(1);
    wr = 1'b0;
    tick(16);
    check("pre_reset_bit3", 16'(txd), 16'd0);
    check("pre_reset_status", dataout, 16'h0023);
    reset = 1'b1;
    tick(1);
    check("reset_txd_next_edge", 16'(txd), 16'd1);
    check("reset_mid_status", dataout, 16'h0001);
    reset = 1'b0;
    exp_q.delete();
    base = rx_count;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (txd !== 1'b1) ok = 1'b0;
    end
    check("post_reset_idle", 16'(ok), 16'd1);
    check("post_reset_no_frames", 16'(rx_count), 16'(base));
    check("post_reset_status", dataout, 16'h0001);

    // 6. data select and push coincident with STOP-end pop at count 3
    statusordata = 1'b0;
    #1;
    check("sod0_idle", dataout, 16'h0000);
    statusordata = 1'b1;
    tick(1);
    base = rx_count;
    quad[0] = 8'hF0; quad[1] = 8'h0F; quad[2] = 8'h96; quad[3] = 8'h69; quad[4] = 8'hC7;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1;
      datain = {8'h00, quad[i]};
      exp_q.push_back(quad[i]);
      tick(1);
    end
    wr = 1'b0;
    statusordata = 1'b0;
    #1;
    check("sod0_busy", dataout, 16'h0000);
    statusordata = 1'b1;
    tick(37);
    check("pre_pop_count3", dataout, 16'h0033);
    wr = 1'b1;
    datain = {8'h00, quad[4]};
    exp_q.push_back(quad[4]);
    tick(1);
    wr = 1'b0;
    check("push_pop_count3", dataout, 16'h0033);
    wait_rx("quad_frames", base + 5, 5 * 40 + 60);
    check("quad_queue_drained", 16'(exp_q.size()), 16'd0);
    tick(5);
    check("final_status", dataout, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
